alu_multiciclo: RTL and testbench

Parametrised, handshaked ALU for the processor datapath, replacing the purely combinational ALU wherever a registered result and multiply support are needed. It keeps the existing `func_3`/`add_sub` operation encoding and adds signed compare, masked shift amounts, an iterative shift-add multiplier on `func_3 = 111`, and valid/ready flow control on both sides. Single-cycle operations complete with a one-cycle registered latency. Multiply takes WIDTH+1 cycles.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/mult_iterativo.sv | 47 ++++
 rtl/alu_multiciclo.sv | 145 ++++++++++++++
 tb/tb_alu_multiciclo.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: operation encodings and FSM states.
package alu_pkg;

    // func_3 encodings, unchanged from the combinational ALU
    localparam logic [2:0] OP_SUMA  = 3'b000;
    localparam logic [2:0] OP_MENOR = 3'b001;
    localparam logic [2:0] OP_SLL   = 3'b010;
    localparam logic [2:0] OP_SR    = 3'b011;
    localparam logic [2:0] OP_OR    = 3'b100;
    localparam logic [2:0] OP_AND   = 3'b101;
    localparam logic [2:0] OP_XOR   = 3'b110;
    localparam logic [2:0] OP_MUL   = 3'b111;

    // Top-level control states: idle, multiply in progress, result held
    typedef enum logic [1:0] {
        ESPERA = 2'd0,
        MULT   = 2'd1,
        LISTO  = 2'd2
    } estado_t;

endpackage

// File: rtl/mult_iterativo.sv
// Iterative shift-add multiplier, one partial-product step per enabled cycle.
// The parent FSM loads it with i_start and steps it with i_step; o_listo flags
// the step whose combinational result o_prodNext is the finished product.
module mult_iterativo #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_start,
    input  logic                 i_step,
    input  logic [WIDTH-1:0]     i_mcand,
    input  logic [WIDTH-1:0]     i_mplier,
    output logic [2*WIDTH-1:0]   o_prodNext,
    output logic                 o_listo
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [2*WIDTH-1:0] r_prod;
    logic [WIDTH-1:0]   r_mcand;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH:0]     w_suma;

    // One step: conditionally add the multiplicand to the upper half keeping the carry, then shift right
    always_comb begin
        w_suma     = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_mcand} : '0);
        o_prodNext = {w_suma, r_prod[WIDTH-1:1]};
        o_listo    = i_step && (r_cnt == CW'(WIDTH - 1));
    end

    // Product register, multiplicand and step counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prod  <= '0;
            r_mcand <= '0;
            r_cnt   <= '0;
        end else if (i_start) begin
            r_prod  <= {{WIDTH{1'b0}}, i_mplier};
            r_mcand <= i_mcand;
            r_cnt   <= '0;
        end else if (i_step) begin
            r_prod  <= o_prodNext;
            r_cnt   <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/alu_multiciclo.sv
// Handshaked ALU with a registered result and an optional iterative multiplier.
// Single-cycle ops finish one cycle after accept; multiply takes WIDTH+1 cycles.
module alu_multiciclo
    import alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int MUL_EN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] x1,
    input  logic [WIDTH-1:0] x2,
    input  logic [2:0]       func_3,
    input  logic             add_sub,
    input  logic             valid_in,
    output logic             ready_out,
    output logic [WIDTH-1:0] resultado,
    output logic             cero,
    output logic             valid_out,
    input  logic             ready_in,
    output logic             ocupado
);

    localparam int SHW = $clog2(WIDTH);

    estado_t              r_estado;
    estado_t              w_estadoNext;
    logic [WIDTH-1:0]     r_resultado;
    logic                 r_cero;
    logic                 r_mulAlta;
    logic [WIDTH-1:0]     w_resNext;
    logic                 w_ceroNext;
    logic                 w_accept;
    logic                 w_esMul;
    logic                 w_lt;
    logic [SHW-1:0]       w_shamt;
    logic [WIDTH-1:0]     w_opRes;
    logic                 w_mulStart;
    logic                 w_mulStep;
    logic [2*WIDTH-1:0]   w_prodNext;
    logic                 w_mulListo;
    logic [WIDTH-1:0]     w_mulRes;

    assign ready_out = (r_estado == ESPERA) || (r_estado == LISTO && ready_in);
    assign valid_out = (r_estado == LISTO);
    assign ocupado   = (r_estado == MULT);
    assign resultado = r_resultado;
    assign cero      = r_cero;

    assign w_accept  = valid_in && ready_out;
    assign w_esMul   = (MUL_EN != 0) && (func_3 == OP_MUL);
    assign w_shamt   = x2[SHW-1:0];
    assign w_mulRes  = r_mulAlta ? w_prodNext[2*WIDTH-1:WIDTH] : w_prodNext[WIDTH-1:0];

    // Single-cycle operation mux; every opcode decoded so the result is never X
    always_comb begin
        w_lt    = add_sub ? ($signed(x1) < $signed(x2)) : (x1 < x2);
        w_opRes = '0;
        case (func_3)
            OP_SUMA:  w_opRes = add_sub ? (x1 - x2) : (x1 + x2);
            OP_MENOR: w_opRes = {{(WIDTH-1){1'b0}}, w_lt};
            OP_SLL:   w_opRes = x1 << w_shamt;
            OP_SR: begin
                if (add_sub) w_opRes = $signed(x1) >>> w_shamt;
                else         w_opRes = x1 >> w_shamt;
            end
            OP_OR:    w_opRes = x1 | x2;
            OP_AND:   w_opRes = x1 & x2;
            OP_XOR:   w_opRes = x1 ^ x2;
            OP_MUL:   w_opRes = '0;
            default:  w_opRes = '0;
        endcase
    end

    generate
        if (MUL_EN != 0) begin : g_mult
            mult_iterativo #(.WIDTH(WIDTH)) u_mult (
                .clk        (clk),
                .rst        (rst),
                .i_start    (w_mulStart),
                .i_step     (w_mulStep),
                .i_mcand    (x1),
                .i_mplier   (x2),
                .o_prodNext (w_prodNext),
                .o_listo    (w_mulListo)
            );
        end else begin : g_sinMult
            assign w_prodNext = '0;
            assign w_mulListo = 1'b0;
        end
    endgenerate

    // Next-state and result-load logic; LISTO with ready_in behaves like ESPERA for a new accept
    always_comb begin
        w_estadoNext = r_estado;
        w_resNext    = r_resultado;
        w_ceroNext   = r_cero;
        w_mulStart   = 1'b0;
        w_mulStep    = 1'b0;
        case (r_estado)
            ESPERA, LISTO: begin
                if (r_estado == LISTO && ready_in) begin
                    w_estadoNext = ESPERA;
                end
                if (w_accept) begin
                    if (w_esMul) begin
                        w_estadoNext = MULT;
                        w_mulStart   = 1'b1;
                    end else begin
                        w_estadoNext = LISTO;
                        w_resNext    = w_opRes;
                        w_ceroNext   = (w_opRes == '0);
                    end
                end
            end
            MULT: begin
                w_mulStep = 1'b1;
                if (w_mulListo) begin
                    w_estadoNext = LISTO;
                    w_resNext    = w_mulRes;
                    w_ceroNext   = (w_mulRes == '0);
                end
            end
            default: w_estadoNext = ESPERA;
        endcase
    end

    // State, registered result and latched multiply half-select
    always_ff @(posedge clk) begin
        if (rst) begin
            r_estado    <= ESPERA;
            r_resultado <= '0;
            r_cero      <= 1'b0;
            r_mulAlta   <= 1'b0;
        end else begin
            r_estado    <= w_estadoNext;
            r_resultado <= w_resNext;
            r_cero      <= w_ceroNext;
            if (w_mulStart) begin
                r_mulAlta <= add_sub;
            end
        end
    end

endmodule

// File: tb/tb_alu_multiciclo.sv
// Scoreboard bench: a 32-bit ALU with multiplier and an 8-bit ALU without one.
module tb_alu_multiciclo;
    import alu_pkg::*;

    typedef struct {
        logic [31:0] res;
        int          cyc;
        string       name;
    } expT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [31:0] x1W = '0, x2W = '0;
    logic [2:0]  f3W = '0;
    logic        asW = 1'b0, vinW = 1'b0, readyInW = 1'b1;
    logic        rdyOutW, ceroW, voutW, ocW;
    logic [31:0] resW;

    logic [7:0]  x1N = '0, x2N = '0;
    logic [2:0]  f3N = '0;
    logic        asN = 1'b0, vinN = 1'b0, readyInN = 1'b1;
    logic        rdyOutN, ceroN, voutN, ocN;
    logic [7:0]  resN;

    int  nChk = 0;
    int  nErr = 0;
    int  cycCount = 0;
    expT qW[$];
    expT qN[$];
    expT eW, eN;

    alu_multiciclo #(.WIDTH(32), .MUL_EN(1)) dutW (
        .clk(clk), .rst(rst), .x1(x1W), .x2(x2W), .func_3(f3W), .add_sub(asW),
        .valid_in(vinW), .ready_out(rdyOutW), .resultado(resW), .cero(ceroW),
        .valid_out(voutW), .ready_in(readyInW), .ocupado(ocW)
    );

    alu_multiciclo #(.WIDTH(8), .MUL_EN(0)) dutN (
        .clk(clk), .rst(rst), .x1(x1N), .x2(x2N), .func_3(f3N), .add_sub(asN),
        .valid_in(vinN), .ready_out(rdyOutN), .resultado(resN), .cero(ceroN),
        .valid_out(voutN), .ready_in(readyInN), .ocupado(ocN)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycCount <= cycCount + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChk++;
        if (act !== exp) begin
            nErr++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one op, wait (bounded) for acceptance, and queue its expected result
    task automatic applyStimulus(input bit narrow, input string name, input logic [2:0] f3,
                                 input logic as, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] exp, input int lat, input bit push);
        bit  ok = 1'b0;
        expT e;
        if (narrow) begin
            x1N = a[7:0]; x2N = b[7:0]; f3N = f3; asN = as; vinN = 1'b1;
        end else begin
            x1W = a; x2W = b; f3W = f3; asW = as; vinW = 1'b1;
        end
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            if (narrow ? rdyOutN : rdyOutW) begin
                ok = 1'b1;
                if (push) begin
                    e.res  = exp;
                    e.cyc  = (lat < 0) ? -1 : cycCount + lat;
                    e.name = name;
                    if (narrow) qN.push_back(e);
                    else        qW.push_back(e);
                end
            end
            @(posedge clk);
            #1;
        end
        if (!ok) checkOutput({name, " accept timeout"}, 32'd0, 32'd1);
        vinW = 1'b0;
        vinN = 1'b0;
    endtask

    // Monitor for the 32-bit DUT: pop and compare on each consumed result
    always @(negedge clk) begin
        if (!rst && voutW && readyInW) begin
            if (qW.size() == 0) begin
                checkOutput("W unexpected valid_out", 32'd1, 32'd0);
            end else begin
                eW = qW.pop_front();
                checkOutput({eW.name, " resultado"}, resW, eW.res);
                checkOutput({eW.name, " cero"}, {31'd0, ceroW}, {31'd0, eW.res == 32'd0});
                if (eW.cyc >= 0) checkOutput({eW.name, " latency"}, 32'(cycCount), 32'(eW.cyc));
            end
        end
    end

    // Monitor for the 8-bit DUT
    always @(negedge clk) begin
        if (!rst && voutN && readyInN) begin
            if (qN.size() == 0) begin
                checkOutput("N unexpected valid_out", 32'd1, 32'd0);
            end else begin
                eN = qN.pop_front();
                checkOutput({eN.name, " resultado"}, {24'd0, resN}, eN.res);
                checkOutput({eN.name, " cero"}, {31'd0, ceroN}, {31'd0, eN.res == 32'd0});
                if (eN.cyc >= 0) checkOutput({eN.name, " latency"}, 32'(cycCount), 32'(eN.cyc));
            end
        end
    end

    task automatic waitDrain();
        for (int k = 0; k < 200 && (qW.size() != 0 || qN.size() != 0); k++) begin
            @(posedge clk);
            #1;
        end
        checkOutput("drain pending", 32'(qW.size() + qN.size()), 32'd0);
    endtask

    initial begin
        int  ocCount;
        bit  rdyBad;
        bit  seen;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset resultado",  resW, 32'd0);
        checkOutput("reset cero",       {31'd0, ceroW}, 32'd0);
        checkOutput("reset valid_out",  {31'd0, voutW}, 32'd0);
        checkOutput("reset ocupado",    {31'd0, ocW}, 32'd0);
        checkOutput("reset ready_out",  {31'd0, rdyOutW}, 32'd1);
        checkOutput("reset N ready_out", {31'd0, rdyOutN}, 32'd1);
        @(posedge clk);
        #1;

        // Back-to-back single-cycle ops
        applyStimulus(0, "add",  OP_SUMA,  0, 32'd5, 32'd7, 32'd12, 1, 1);
        applyStimulus(0, "sub",  OP_SUMA,  1, 32'd5, 32'd7, 32'hFFFF_FFFE, 1, 1);
        applyStimulus(0, "xor",  OP_XOR,   0, 32'hF0F0_F0F0, 32'hFFFF_0000, 32'h0F0F_F0F0, 1, 1);
        applyStimulus(0, "sltu", OP_MENOR, 0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1, 1);
        applyStimulus(0, "slt",  OP_MENOR, 1, 32'hFFFF_FFFF, 32'd1, 32'd1, 1, 1);
        applyStimulus(0, "sra",  OP_SR,    1, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 1, 1);
        applyStimulus(0, "srl",  OP_SR,    0, 32'h8000_0000, 32'h0000_0024, 32'h0800_0000, 1, 1);
        applyStimulus(0, "sll",  OP_SLL,   0, 32'h0000_0001, 32'h0000_0021, 32'h0000_0002, 1, 1);
        applyStimulus(0, "addz", OP_SUMA,  0, 32'd5, 32'hFFFF_FFFB, 32'd0, 1, 1);
        waitDrain();

        // Multiply low half with occupancy count and ignored valid_in pulses
        applyStimulus(0, "mul lo", OP_MUL, 0, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 33, 1);
        ocCount = 0;
        rdyBad  = 1'b0;
        seen    = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            if (k == 5) begin
                x1W = 32'd3; x2W = 32'd4; f3W = OP_SUMA; asW = 1'b0; vinW = 1'b1;
            end
            if (k == 8) vinW = 1'b0;
            @(negedge clk);
            if (voutW) begin
                seen = 1'b1;
            end else begin
                if (ocW) ocCount++;
                if (rdyOutW) rdyBad = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        checkOutput("mul result seen",   {31'd0, seen}, 32'd1);
        checkOutput("mul ocupado cycles", 32'(ocCount), 32'd32);
        checkOutput("mul ready_out low",  {31'd0, rdyBad}, 32'd0);

        applyStimulus(0, "mul hi",   OP_MUL, 1, 32'hFFFF_FFFF, 32'd2, 32'd1, 33, 1);
        waitDrain();
        applyStimulus(0, "mul zero", OP_MUL, 0, 32'h0001_0000, 32'h0001_0000, 32'd0, 33, 1);
        waitDrain();

        // Backpressure: result held five cycles, then release with a new op in the same cycle
        readyInW = 1'b0;
        applyStimulus(0, "or held", OP_OR, 0, 32'h00FF_00FF, 32'h0F00_0000, 32'h0FFF_00FF, -1, 1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput("held resultado", resW, 32'h0FFF_00FF);
            checkOutput("held ready_out", {31'd0, rdyOutW}, 32'd0);
            checkOutput("held valid_out", {31'd0, voutW}, 32'd1);
            @(posedge clk);
            #1;
        end
        readyInW = 1'b1;
        applyStimulus(0, "and nobubble", OP_AND, 0, 32'hFFFF_0000, 32'h1234_5678, 32'h1234_0000, 1, 1);
        waitDrain();

        // Reset in the middle of a multiply discards it
        applyStimulus(0, "mul aborted", OP_MUL, 0, 32'd7, 32'd9, 32'd63, 33, 0);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("abort valid_out", {31'd0, voutW}, 32'd0);
        checkOutput("abort resultado", resW, 32'd0);
        checkOutput("abort ocupado",   {31'd0, ocW}, 32'd0);
        checkOutput("abort ready_out", {31'd0, rdyOutW}, 32'd1);
        @(posedge clk);
        #1;
        applyStimulus(0, "add after abort", OP_SUMA, 0, 32'd1, 32'd1, 32'd2, 1, 1);
        waitDrain();

        // 8-bit instance without multiplier
        applyStimulus(1, "N mul off", OP_MUL, 0, 32'h5A, 32'h03, 32'd0, 1, 1);
        applyStimulus(1, "N sll",     OP_SLL, 0, 32'h01, 32'h09, 32'h02, 1, 1);
        applyStimulus(1, "N sub",     OP_SUMA, 1, 32'h03, 32'h05, 32'hFE, 1, 1);
        waitDrain();

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", nErr, nChk);
        $finish;
    end

endmodule
